// File: rtl/fu_alu_pipe_if.sv
// ============================================================================
// Module      : fu_alu_pipe_if
// Description : Issue, result and flush bundle between the ALU reservation
//               station / CDB arbiter and the pipelined ALU functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fu_alu_pipe_if #(
   parameter int XLEN      = 32,
   parameter int ROB_TAG_W = 5,
   parameter int PREG_W    = 7
);
   logic                 issue_valid;
   logic                 issue_ready;
   logic [6:0]           opcode;
   logic [2:0]           func3;
   logic [6:0]           func7;
   logic [XLEN-1:0]      imm;
   logic [PREG_W-1:0]    pd;
   logic [ROB_TAG_W-1:0] rob_index;
   logic [XLEN-1:0]      ps1_data;
   logic [XLEN-1:0]      ps2_data;
   logic [ROB_TAG_W-1:0] curr_rob_tag;
   logic                 mispredict;
   logic [ROB_TAG_W-1:0] mispredict_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [PREG_W-1:0]    out_pd;
   logic [ROB_TAG_W-1:0] out_rob;
   logic [XLEN-1:0]      out_data;

   modport master (
      output issue_valid, opcode, func3, func7, imm, pd, rob_index,
             ps1_data, ps2_data, curr_rob_tag, mispredict, mispredict_tag,
             out_ready,
      input  issue_ready, out_valid, out_pd, out_rob, out_data
   );

   modport slave (
      input  issue_valid, opcode, func3, func7, imm, pd, rob_index,
             ps1_data, ps2_data, curr_rob_tag, mispredict, mispredict_tag,
             out_ready,
      output issue_ready, out_valid, out_pd, out_rob, out_data
   );
endinterface

`default_nettype wire

// File: rtl/fu_alu_pipe.sv
// ============================================================================
// Module      : fu_alu_pipe
// Description : Pipelined RV32I integer ALU functional unit with valid/ready
//               backpressure and ROB-tag based squash of wrong-path entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_alu_pipe #(
   parameter int XLEN      = 32,
   parameter int STAGES    = 2,
   parameter int ROB_DEPTH = 16,
   parameter int ROB_TAG_W = 5,
   parameter int PREG_W    = 7
) (
   input  logic           clk,
   input  logic           reset,
   fu_alu_pipe_if.slave   bus
);
   localparam int                   c_shw      = $clog2(XLEN);
   localparam logic [6:0]           c_op_imm   = 7'b0010011;
   localparam logic [6:0]           c_op_reg   = 7'b0110011;
   localparam logic [6:0]           c_op_lui   = 7'b0110111;
   localparam logic [ROB_TAG_W-1:0] c_rob_last = ROB_TAG_W'(ROB_DEPTH - 1);

   logic [STAGES-1:0]                 r_v;
   logic [STAGES-1:0][PREG_W-1:0]     r_pd;
   logic [STAGES-1:0][ROB_TAG_W-1:0]  r_rob;
   logic [STAGES-1:0][XLEN-1:0]       r_data;

   logic [XLEN-1:0]                   w_a;
   logic [XLEN-1:0]                   w_b;
   logic [XLEN-1:0]                   w_result;
   logic [c_shw-1:0]                  w_shamt;
   logic                              w_is_reg;
   logic                              w_f7_zero;
   logic                              w_f7_alt;
   logic                              w_plain_ok;
   logic [ROB_TAG_W-1:0]              w_ptr;
   logic [STAGES:0]                   w_en;
   logic [STAGES-1:0]                 w_in_v;
   logic [STAGES-1:0][PREG_W-1:0]     w_in_pd;
   logic [STAGES-1:0][ROB_TAG_W-1:0]  w_in_rob;
   logic [STAGES-1:0][XLEN-1:0]       w_in_data;
   logic [STAGES-1:0]                 w_kill_in;
   logic [STAGES-1:0]                 w_kill_hold;

   // Circular membership in [ptr, tail); ptr == tail is the empty range.
   function automatic logic f_in_range(input logic [ROB_TAG_W-1:0] t,
                                       input logic [ROB_TAG_W-1:0] ptr,
                                       input logic [ROB_TAG_W-1:0] tail);
      logic hit;
      if (ptr <= tail) hit = (t >= ptr) && (t < tail);
      else             hit = (t >= ptr) || (t < tail);
      return hit;
   endfunction

   always_comb begin
      w_is_reg   = (bus.opcode == c_op_reg);
      w_a        = bus.ps1_data;
      w_b        = w_is_reg ? bus.ps2_data : bus.imm;
      w_shamt    = w_b[c_shw-1:0];
      w_f7_zero  = (bus.func7 == 7'b0000000);
      w_f7_alt   = (bus.func7 == 7'b0100000);
      // Outside shifts, func7 is immediate payload for I-type ops.
      w_plain_ok = !w_is_reg || w_f7_zero;
      w_result   = '0;
      if (bus.opcode == c_op_lui) begin
         w_result = bus.imm;
      end else if (bus.opcode == c_op_imm || w_is_reg) begin
         case (bus.func3)
            3'b000: begin
               if (w_is_reg && w_f7_alt) w_result = w_a - w_b;
               else if (w_plain_ok)      w_result = w_a + w_b;
            end
            3'b001: if (w_f7_zero) w_result = w_a << w_shamt;
            3'b010: if (w_plain_ok)
               w_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            3'b011: if (w_plain_ok)
               w_result = {{(XLEN-1){1'b0}}, (w_a < w_b)};
            3'b100: if (w_plain_ok) w_result = w_a ^ w_b;
            3'b101: begin
               if (w_f7_alt)       w_result = $unsigned($signed(w_a) >>> w_shamt);
               else if (w_f7_zero) w_result = w_a >> w_shamt;
            end
            3'b110: if (w_plain_ok) w_result = w_a | w_b;
            default: if (w_plain_ok) w_result = w_a & w_b;
         endcase
      end
   end

   always_comb begin
      w_ptr = (bus.mispredict_tag == c_rob_last) ? '0
            : bus.mispredict_tag + ROB_TAG_W'(1);

      // A stage may load when it is empty or its contents move on this edge.
      w_en         = '0;
      w_en[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_en[k] = !r_v[k] || w_en[k+1];
      end

      w_in_v[0]    = bus.issue_valid && w_en[0];
      w_in_pd[0]   = bus.pd;
      w_in_rob[0]  = bus.rob_index;
      w_in_data[0] = w_result;
      for (int k = 1; k < STAGES; k++) begin
         w_in_v[k]    = r_v[k-1];
         w_in_pd[k]   = r_pd[k-1];
         w_in_rob[k]  = r_rob[k-1];
         w_in_data[k] = r_data[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         w_kill_in[k]   = bus.mispredict && f_in_range(w_in_rob[k], w_ptr, bus.curr_rob_tag);
         w_kill_hold[k] = bus.mispredict && f_in_range(r_rob[k], w_ptr, bus.curr_rob_tag);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_v    <= '0;
         r_pd   <= '0;
         r_rob  <= '0;
         r_data <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_en[k]) begin
               r_v[k] <= w_in_v[k] && !w_kill_in[k];
               if (w_in_v[k]) begin
                  r_pd[k]   <= w_in_pd[k];
                  r_rob[k]  <= w_in_rob[k];
                  r_data[k] <= w_in_data[k];
               end
            end else begin
               r_v[k] <= r_v[k] && !w_kill_hold[k];
            end
         end
      end
   end

   assign bus.issue_ready = w_en[0];
   assign bus.out_valid   = r_v[STAGES-1] && !w_kill_hold[STAGES-1];
   assign bus.out_pd      = r_pd[STAGES-1];
   assign bus.out_rob     = r_rob[STAGES-1];
   assign bus.out_data    = r_data[STAGES-1];

endmodule

`default_nettype wire
